// File: rtl/issue_sel.sv
// issue_sel: picks issue-queue entries for the MUL, ADDR and ALU ports
// every cycle. The search is round-robin from rr_ptr. Grants are registered
// into per-port output flops, and matching wait-clear pulses are generated.

// Output register for one issue port. Flush clears it, stall holds it,
// otherwise it captures this cycle's grant (or empties when there is no grant).
module issue_sel_port #(
    parameter int PKT_WIDTH = 66
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 gnt,
    input  logic [PKT_WIDTH-1:0] pkt_in,
    output logic                 vld,
    output logic [PKT_WIDTH-1:0] pkt
);
    logic                 vld_d, vld_q;
    logic [PKT_WIDTH-1:0] pkt_d, pkt_q;

    // next value: flush beats stall, and stall beats a new grant
    always_comb begin
        vld_d = vld_q;
        pkt_d = pkt_q;
        if (flush) begin
            vld_d = 1'b0;
            pkt_d = '0;
        end else if (!stall) begin
            vld_d = gnt;
            pkt_d = gnt ? pkt_in : '0;
        end
    end

    // output register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            pkt_q <= '0;
        end else begin
            vld_q <= vld_d;
            pkt_q <= pkt_d;
        end
    end

    assign vld = vld_q;
    assign pkt = pkt_q;
endmodule

module issue_sel #(
    parameter int ISQ_DEPTH = 64,
    parameter int IDX_BITS  = 6,
    parameter int PKT_WIDTH = 66,
    parameter int NUM_ALU   = 2,
    parameter int MUL_LAT   = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ISQ_DEPTH-1:0]           ent_rdy,
    input  logic [2*ISQ_DEPTH-1:0]         ent_cls_flat,
    input  logic [PKT_WIDTH*ISQ_DEPTH-1:0] ent_pkt_flat,
    input  logic [NUM_ALU+1:0]             fun_rdy_frm_exe,
    input  logic                           stall_frm_rf,
    input  logic                           flush,
    input  logic                           br_done_vld,
    input  logic [IDX_BITS-1:0]            br_done_idx,
    output logic                           mul_vld,
    output logic [PKT_WIDTH-1:0]           mul_pkt,
    output logic                           adr_vld,
    output logic [PKT_WIDTH-1:0]           adr_pkt,
    output logic [NUM_ALU-1:0]             alu_vld,
    output logic [NUM_ALU*PKT_WIDTH-1:0]   alu_pkt_flat,
    output logic [ISQ_DEPTH-1:0]           clr_inst_wat,
    output logic                           mul_busy
);
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);

    logic [IDX_BITS-1:0]  rr_ptr_d, rr_ptr_q;
    logic [CNT_W-1:0]     mul_cnt_d, mul_cnt_q;
    logic [ISQ_DEPTH-1:0] clr_d, clr_q;

    logic [ISQ_DEPTH-1:0] mul_mask, adr_mask, br_mask, int_mask;

    logic                              gnt_en;
    logic                              mul_gnt, adr_gnt;
    logic [IDX_BITS-1:0]               mul_idx, adr_idx;
    logic [NUM_ALU-1:0]                alu_gnt;
    logic [NUM_ALU-1:0][IDX_BITS-1:0]  alu_idx;
    logic [PKT_WIDTH-1:0]              mul_sel, adr_sel;
    logic [NUM_ALU-1:0][PKT_WIDTH-1:0] alu_sel;
    logic [NUM_ALU-1:0][PKT_WIDTH-1:0] alu_pkt_q;

    // First set bit of mask, searching upward from ptr with wrap.
    // The result is {hit, index}. Walking the offsets from high to low lets
    // the smallest offset win without needing an early exit.
    function automatic logic [IDX_BITS:0] find_first(
        input logic [ISQ_DEPTH-1:0] mask,
        input logic [IDX_BITS-1:0]  ptr
    );
        logic [IDX_BITS:0]   res;
        logic [IDX_BITS-1:0] j;
        res = '0;
        for (int i = ISQ_DEPTH - 1; i >= 0; i--) begin
            j = ptr + IDX_BITS'(i);
            if (mask[j]) res = {1'b1, j};
        end
        return res;
    endfunction

    // split the ready vector into one candidate mask per class
    always_comb begin
        mul_mask = '0;
        adr_mask = '0;
        br_mask  = '0;
        int_mask = '0;
        for (int i = 0; i < ISQ_DEPTH; i++) begin
            mul_mask[i] = ent_rdy[i] && (ent_cls_flat[2*i +: 2] == 2'b01);
            adr_mask[i] = ent_rdy[i] && (ent_cls_flat[2*i +: 2] == 2'b10);
            br_mask[i]  = ent_rdy[i] && (ent_cls_flat[2*i +: 2] == 2'b11);
            int_mask[i] = ent_rdy[i] && (ent_cls_flat[2*i +: 2] == 2'b00);
        end
    end

    // Port selection. ALU candidates are chosen without looking at fun_rdy,
    // so a busy ALU does not move later ALUs onto different entries. Each
    // candidate is removed from the pool for the ALUs that come after it.
    always_comb begin
        logic [IDX_BITS:0]    r;
        logic [ISQ_DEPTH-1:0] taken;
        logic [ISQ_DEPTH-1:0] m;
        gnt_en  = !stall_frm_rf && !flush;
        r       = find_first(mul_mask, rr_ptr_q);
        mul_idx = r[IDX_BITS-1:0];
        mul_gnt = gnt_en && fun_rdy_frm_exe[0] && (mul_cnt_q == '0) && r[IDX_BITS];
        r       = find_first(adr_mask, rr_ptr_q);
        adr_idx = r[IDX_BITS-1:0];
        adr_gnt = gnt_en && fun_rdy_frm_exe[1] && r[IDX_BITS];
        taken   = '0;
        alu_gnt = '0;
        alu_idx = '0;
        for (int k = 0; k < NUM_ALU; k++) begin
            m          = (k == 0) ? (int_mask | br_mask) : (int_mask & ~taken);
            r          = find_first(m, rr_ptr_q);
            alu_idx[k] = r[IDX_BITS-1:0];
            alu_gnt[k] = gnt_en && fun_rdy_frm_exe[2+k] && r[IDX_BITS];
            if (r[IDX_BITS]) taken[r[IDX_BITS-1:0]] = 1'b1;
        end
    end

    // packet muxes from the flattened queue
    always_comb begin
        mul_sel = ent_pkt_flat[int'(mul_idx)*PKT_WIDTH +: PKT_WIDTH];
        adr_sel = ent_pkt_flat[int'(adr_idx)*PKT_WIDTH +: PKT_WIDTH];
        for (int k = 0; k < NUM_ALU; k++)
            alu_sel[k] = ent_pkt_flat[int'(alu_idx[k])*PKT_WIDTH +: PKT_WIDTH];
    end

    // Next state for the pointer, the multiplier counter and the wait-clear
    // pulses. Branch/jump entries keep waiting until they resolve, so an ALU0
    // grant only clears the wait when the granted entry is class 00.
    always_comb begin
        rr_ptr_d  = alu_gnt[0] ? alu_idx[0] + 1'b1 : rr_ptr_q;
        mul_cnt_d = mul_gnt ? MUL_LOAD : ((mul_cnt_q != '0) ? mul_cnt_q - 1'b1 : '0);
        clr_d     = '0;
        if (mul_gnt) clr_d[mul_idx] = 1'b1;
        if (adr_gnt) clr_d[adr_idx] = 1'b1;
        for (int k = 0; k < NUM_ALU; k++)
            if (alu_gnt[k] && int_mask[alu_idx[k]]) clr_d[alu_idx[k]] = 1'b1;
        if (br_done_vld) clr_d[br_done_idx] = 1'b1;
    end

    // control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            mul_cnt_q <= '0;
            clr_q     <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            mul_cnt_q <= mul_cnt_d;
            clr_q     <= clr_d;
        end
    end

    issue_sel_port #(.PKT_WIDTH(PKT_WIDTH)) u_mul (
        .clk(clk), .rst(rst), .stall(stall_frm_rf), .flush(flush),
        .gnt(mul_gnt), .pkt_in(mul_sel), .vld(mul_vld), .pkt(mul_pkt)
    );

    issue_sel_port #(.PKT_WIDTH(PKT_WIDTH)) u_adr (
        .clk(clk), .rst(rst), .stall(stall_frm_rf), .flush(flush),
        .gnt(adr_gnt), .pkt_in(adr_sel), .vld(adr_vld), .pkt(adr_pkt)
    );

    for (genvar k = 0; k < NUM_ALU; k++) begin : g_alu
        issue_sel_port #(.PKT_WIDTH(PKT_WIDTH)) u_alu (
            .clk(clk), .rst(rst), .stall(stall_frm_rf), .flush(flush),
            .gnt(alu_gnt[k]), .pkt_in(alu_sel[k]), .vld(alu_vld[k]), .pkt(alu_pkt_q[k])
        );
    end

    assign alu_pkt_flat = alu_pkt_q;
    assign clr_inst_wat = clr_q;
    assign mul_busy     = (mul_cnt_q != '0);
endmodule

// File: doc/issue_sel.md
ISSUE_SEL -- requirements
Module: issue_sel

Interface
REQ-001 SHALL have parameter ISQ_DEPTH, default 64, number of issue-queue entries.
REQ-002 SHALL have parameter IDX_BITS, default 6, entry index width; 2^IDX_BITS == ISQ_DEPTH.
REQ-003 SHALL have parameter PKT_WIDTH, default 66, per-entry issue packet width.
REQ-004 SHALL have parameter NUM_ALU, default 2, ALU port count (1..4).
REQ-005 SHALL have parameter MUL_LAT, default 3, multiplier occupancy in cycles (>=1).
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst  input  1  synchronous active-high reset.
REQ-008 SHALL have port ent_rdy  input  ISQ_DEPTH  entry valid, waiting, operands ready.
REQ-009 SHALL have port ent_cls_flat  input  2*ISQ_DEPTH  per-entry class: 00 ALU, 01 MUL, 10 ADDR, 11 BR/JMP.
REQ-010 SHALL have port ent_pkt_flat  input  PKT_WIDTH*ISQ_DEPTH  per-entry packet, entry i at bits [PKT_WIDTH*(i+1)-1 : PKT_WIDTH*i].
REQ-011 SHALL have port fun_rdy_frm_exe  input  NUM_ALU+2  bit0 MUL, bit1 ADDR, bit 2+k ALU k.
REQ-012 SHALL have port stall_frm_rf  input  1  RF stage cannot accept.
REQ-013 SHALL have port flush  input  1  squash outputs.
REQ-014 SHALL have ports br_done_vld  input  1  and br_done_idx  input  IDX_BITS  resolved branch entry.
REQ-015 SHALL have ports mul_vld / mul_pkt, adr_vld / adr_pkt  output  1 / PKT_WIDTH  registered port outputs.
REQ-016 SHALL have ports alu_vld  output  NUM_ALU  and alu_pkt_flat  output  NUM_ALU*PKT_WIDTH  registered ALU outputs.
REQ-017 SHALL have port clr_inst_wat  output  ISQ_DEPTH  registered one-cycle wait-clear pulses.
REQ-018 SHALL have port mul_busy  output  1  multiplier occupied.

Function
REQ-019 Search order SHALL start at rr_ptr and wrap modulo ISQ_DEPTH; "first" means first in this order.
REQ-020 MUL grant SHALL be first ent_rdy entry of class 01, only when fun_rdy bit0 = 1 and mul_cnt = 0.
REQ-021 ADDR grant SHALL be first ent_rdy entry of class 10 when fun_rdy bit1 = 1.
REQ-022 ALU0 grant SHALL be first ent_rdy entry of class 00 or 11; BR/JMP SHALL never go to ALU k>0.
REQ-023 ALU k>0 grant SHALL be first ent_rdy class-00 entry not granted to ALU 0..k-1; an entry SHALL never be granted to two ports.
REQ-024 A port whose fun_rdy bit is 0 SHALL not grant, and SHALL not shift grants of other ALU ports (later ALUs still skip entries already taken).
REQ-025 Latency: grants in cycle N SHALL appear as *_vld=1 with the entry packet copied unmodified on *_pkt at cycle N+1.
REQ-026 Ports without grant SHALL drive vld=0 and pkt=0 next cycle.
REQ-027 stall_frm_rf=1 SHALL suppress all grants, hold all *_vld/*_pkt registers, and leave rr_ptr unchanged.
REQ-028 flush=1 SHALL suppress grants and clear all *_vld/*_pkt next cycle; flush SHALL take priority over stall.
REQ-029 rr_ptr SHALL become (ALU0 grant index + 1) mod ISQ_DEPTH on an ALU0 grant, else hold.
REQ-030 mul_cnt SHALL load MUL_LAT-1 on MUL grant, else decrement to 0 saturating; decrement SHALL continue under stall and flush; mul_busy = (mul_cnt != 0).
REQ-031 clr_inst_wat SHALL pulse, in cycle N+1, bit of each granted entry of class 00/01/10; BR/JMP grants SHALL NOT clear wait at issue.
REQ-032 br_done_vld=1 in cycle N SHALL set clr_inst_wat[br_done_idx] in cycle N+1, ORed with grant-based bits.
REQ-033 clr_inst_wat SHALL be 0 in any cycle not driven by REQ-031/032; br_done SHALL be honoured under stall and flush.

Reset
REQ-034 rst=1 at a clock edge SHALL set all *_vld, *_pkt, clr_inst_wat, rr_ptr, mul_cnt to 0, overriding all other inputs, including mid-multiply.
REQ-035 First grants SHALL be possible in the cycle rst deasserts, appearing the following cycle.

Verification
REQ-036 ent_rdy[5],[9] class 00, all fun_rdy=1, rr_ptr=0 -> next cycle alu_vld=2'b11, ALU0 pkt=entry5, ALU1 pkt=entry9, clr_inst_wat bits 5,9, rr_ptr=6.
REQ-037 rr_ptr=62, ent_rdy[1],[63] class 00 -> ALU0=entry63, ALU1=entry1, rr_ptr wraps to 0.
REQ-038 MUL_LAT=3, class-01 entries 2 and 4 ready continuously -> entry2 issued, mul_busy 2 cycles, entry4 issued 3 cycles after entry2.
REQ-039 entry7 class 11 granted -> alu_vld[0]=1, clr_inst_wat[7]=0; later br_done_vld=1, idx=7 -> clr_inst_wat[7]=1 one cycle.
REQ-040 stall_frm_rf=1 with ready entries -> outputs hold prior values, clr_inst_wat=0; flush and stall together -> all *_vld=0 next cycle.
REQ-041 rst asserted with mul_busy=1 and valid outputs -> next cycle all outputs 0, mul_busy=0.
